reg_dump_tx: RTL and testbench

REG_DUMP_TX -- requirements
Module: reg_dump_tx

---
 rtl/reg_dump_tx.sv | 199 +++++++++++++++++++
 tb/tb_reg_dump_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: streams the CPU register file over UART 8N1 as header 0xA5 plus four bytes per register, MSB first.
// Define REG_DUMP_TRACE_PC_EN to also send PC and Instr, latched at start, between the header and x0.
module reg_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_REGS     = 32
) (
    input  logic        CLOCK,
    input  logic        Reset,
    input  logic        start,
    output logic [4:0]  Regin,
    input  logic [31:0] Regout,
    input  logic [31:0] PC,
    input  logic [31:0] Instr,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 4;
    localparam int unsigned REG_W = 6;
    localparam logic [7:0]       HEADER   = 8'hA5;
    localparam logic [BIT_W-1:0] STOP_BIT = BIT_W'(9);

    typedef enum logic [2:0] {IDLE, SELECT, SAMPLE, LOAD, TX_BIT} state_t;
    typedef enum logic [1:0] {PH_HDR, PH_PC, PH_INSTR, PH_REGS} phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [CNT_W-1:0]  clk_q, clk_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [1:0]        rem_q, rem_d;
    logic [REG_W-1:0]  reg_cnt_q, reg_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [7:0]        byte_q, byte_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef REG_DUMP_TRACE_PC_EN
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
`else
    logic              unused_c;
    assign unused_c = ^{PC, Instr};
`endif

    assign Regin = reg_cnt_q[4:0];
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

    // State and datapath registers
    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            phase_q   <= PH_HDR;
            clk_q     <= '0;
            bit_q     <= '0;
            rem_q     <= '0;
            reg_cnt_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef REG_DUMP_TRACE_PC_EN
            pc_q      <= '0;
            instr_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            clk_q     <= clk_d;
            bit_q     <= bit_d;
            rem_q     <= rem_d;
            reg_cnt_q <= reg_cnt_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef REG_DUMP_TRACE_PC_EN
            pc_q      <= pc_d;
            instr_q   <= instr_d;
`endif
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        clk_d     = clk_q;
        bit_d     = bit_q;
        rem_d     = rem_q;
        reg_cnt_d = reg_cnt_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef REG_DUMP_TRACE_PC_EN
        pc_d      = pc_q;
        instr_d   = instr_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // done_q blocks a start that coincides with the completion pulse
                if (start && !done_q) begin
                    state_d   = SELECT;
                    phase_d   = PH_HDR;
                    reg_cnt_d = '0;
                    busy_d    = 1'b1;
`ifdef REG_DUMP_TRACE_PC_EN
                    pc_d      = PC;
                    instr_d   = Instr;
`endif
                end
            end

            SELECT: begin
                state_d = SAMPLE;
            end

            SAMPLE: begin
                state_d = LOAD;
                rem_d   = 2'd3;
                case (phase_q)
                    PH_HDR: begin
                        shift_d = {HEADER, 24'h0};
                        rem_d   = 2'd0;
                    end
`ifdef REG_DUMP_TRACE_PC_EN
                    PH_PC:    shift_d = pc_q;
                    PH_INSTR: shift_d = instr_q;
`endif
                    default:  shift_d = Regout;
                endcase
            end

            LOAD: begin
                byte_d  = shift_q[31:24];
                shift_d = {shift_q[23:0], 8'h00};
                tx_d    = 1'b0;
                clk_d   = '0;
                bit_d   = '0;
                state_d = TX_BIT;
            end

            TX_BIT: begin
                if (clk_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_d = '0;
                    if (bit_q == STOP_BIT) begin
                        tx_d  = 1'b1;
                        bit_d = '0;
                        if (rem_q != 2'd0) begin
                            rem_d   = rem_q - 2'd1;
                            state_d = LOAD;
                        end else if (phase_q == PH_REGS &&
                                     reg_cnt_q == REG_W'(NUM_REGS - 1)) begin
                            state_d   = IDLE;
                            phase_d   = PH_HDR;
                            reg_cnt_d = '0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end else begin
                            state_d = SELECT;
                            case (phase_q)
`ifdef REG_DUMP_TRACE_PC_EN
                                PH_HDR:   phase_d = PH_PC;
                                PH_PC:    phase_d = PH_INSTR;
`endif
                                PH_REGS:  reg_cnt_d = reg_cnt_q + REG_W'(1);
                                default:  phase_d = PH_REGS;
                            endcase
                        end
                    end else begin
                        // Shifting in ones leaves the stop bit at byte_q[0] after eight data bits
                        bit_d  = bit_q + BIT_W'(1);
                        tx_d   = byte_q[0];
                        byte_d = {1'b1, byte_q[7:1]};
                    end
                end else begin
                    clk_d = clk_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: scoreboard bench for reg_dump_tx; instance a has 2 registers, instance b the full 32.
// Honours REG_DUMP_TRACE_PC_EN when it is defined for the whole build.
module tb_reg_dump_tx;

    localparam int unsigned CPB       = 4;
    localparam int unsigned NR_A      = 2;
    localparam int unsigned NR_B      = 32;
    localparam int unsigned FRAME_LEN = 10 * CPB;
    localparam int          BUDGET    = 20000;

    logic        CLOCK = 1'b0;
    logic        Reset;
    logic        start_a, start_b;
    logic [31:0] PC, Instr;
    logic [4:0]  Regin_a, Regin_b;
    logic [31:0] Regout_a, Regout_b;
    logic [1:0]  tx_v, busy_v, done_v;
    logic        glitch_a;
    logic [4:0]  regin_a_prev;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    int mon_act[2], mon_cnt[2], gap[2], had_frame[2], frames_started[2], done_cnt[2];
    logic [FRAME_LEN-1:0] mon_bits[2];
    int regin_prev, regin_max;

    always #5 CLOCK = ~CLOCK;

    reg_dump_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(NR_A)) u_dut_a (
        .CLOCK (CLOCK),    .Reset (Reset),     .start (start_a),
        .Regin (Regin_a),  .Regout(Regout_a),  .PC    (PC),
        .Instr (Instr),    .tx    (tx_v[0]),   .busy  (busy_v[0]),
        .done  (done_v[0])
    );

    reg_dump_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(NR_B)) u_dut_b (
        .CLOCK (CLOCK),    .Reset (Reset),     .start (start_b),
        .Regin (Regin_b),  .Regout(Regout_b),  .PC    (PC),
        .Instr (Instr),    .tx    (tx_v[1]),   .busy  (busy_v[1]),
        .done  (done_v[1])
    );

    function automatic logic [31:0] model_a(input int r);
        if (r == 0) return 32'h11223344;
        if (r == 1) return 32'hDEADBEEF;
        return 32'h0;
    endfunction

    // Register file a may show a junk value in the cycle Regin changes
    always @(posedge CLOCK) regin_a_prev <= Regin_a;
    assign Regout_a = (glitch_a && Regin_a != regin_a_prev) ? 32'hBAD0BAD0
                                                            : model_a(int'(Regin_a));
    assign Regout_b = 32'(Regin_b) * 32'h01010101;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FRAME_LEN-1:0] frame_vec(input logic [7:0] b);
        logic [9:0] f;
        logic [FRAME_LEN-1:0] v;
        f = {1'b1, b, 1'b0};
        for (int c = 0; c < int'(FRAME_LEN); c++) v[c] = f[c / int'(CPB)];
        return v;
    endfunction

    task automatic push_byte(input int k, input logic [7:0] b);
        if (k == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    task automatic push_word(input int k, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) push_byte(k, w[8*i +: 8]);
    endtask

    task automatic push_dump(input int k);
        int nr;
        nr = (k == 0) ? int'(NR_A) : int'(NR_B);
        push_byte(k, 8'hA5);
`ifdef REG_DUMP_TRACE_PC_EN
        push_word(k, PC);
        push_word(k, Instr);
`endif
        for (int r = 0; r < nr; r++)
            push_word(k, (k == 0) ? model_a(r) : 32'(r) * 32'h01010101);
    endtask

    // Completed frame: compare the 40 line samples against the next expected byte
    task automatic frame_done(input int k);
        logic [FRAME_LEN-1:0] expv;
        expv = '1;
        if (k == 0 && exp_q0.size() > 0) expv = frame_vec(exp_q0.pop_front());
        if (k == 1 && exp_q1.size() > 0) expv = frame_vec(exp_q1.pop_front());
        check((k == 0) ? "frame_a" : "frame_b", 64'(mon_bits[k]), 64'(expv));
    endtask

    // UART line monitor, sampled on the falling edge
    always @(negedge CLOCK) begin
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                mon_act[k]   = 0;
                gap[k]       = 0;
                had_frame[k] = 0;
            end else begin
                if (done_v[k]) done_cnt[k]++;
                if (mon_act[k] == 0) begin
                    if (tx_v[k] == 1'b0) begin
                        if (had_frame[k] != 0)
                            check("inter_byte_gap_le3", 64'(gap[k] <= 3), 64'(1));
                        mon_act[k]     = 1;
                        mon_bits[k]    = '1;
                        mon_bits[k][0] = tx_v[k];
                        mon_cnt[k]     = 1;
                        frames_started[k]++;
                    end else if (busy_v[k]) begin
                        gap[k]++;
                    end else begin
                        had_frame[k] = 0;
                        gap[k]       = 0;
                    end
                end else begin
                    mon_bits[k][mon_cnt[k]] = tx_v[k];
                    mon_cnt[k]++;
                    if (mon_cnt[k] == int'(FRAME_LEN)) begin
                        mon_act[k]   = 0;
                        gap[k]       = 0;
                        had_frame[k] = 1;
                        frame_done(k);
                    end
                end
            end
        end
    end

    // Regin of instance b must step 0,1,..,31 while busy
    always @(negedge CLOCK) begin
        if (Reset || !busy_v[1]) begin
            regin_prev = 0;
        end else if (int'(Regin_b) != regin_prev) begin
            check("regin_seq", 64'(Regin_b), 64'(regin_prev + 1));
            regin_prev = int'(Regin_b);
            if (regin_prev > regin_max) regin_max = regin_prev;
        end
    end

    task automatic set_start(input int k, input logic v);
        if (k == 0) start_a = v;
        else        start_b = v;
    endtask

    task automatic pulse_start(input int k);
        @(posedge CLOCK); #1;
        set_start(k, 1'b1);
        push_dump(k);
        @(posedge CLOCK); #1;
        set_start(k, 1'b0);
        PC    = $urandom;
        Instr = $urandom;
    endtask

    task automatic wait_frames(input int k, input int target, input string tag);
        int n;
        n = 0;
        while (frames_started[k] < target && n < BUDGET) begin
            @(negedge CLOCK);
            n++;
        end
        check({tag, "_frames_reached"}, 64'(frames_started[k] >= target), 64'(1));
    endtask

    task automatic wait_done(input int k, input string tag, input bit start_in_done);
        int n;
        n = 0;
        @(negedge CLOCK);
        while (done_v[k] !== 1'b1 && n < BUDGET) begin
            @(negedge CLOCK);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_v[k]), 64'(1));
        if (done_v[k] === 1'b1) begin
            check({tag, "_busy_at_done"}, 64'(busy_v[k]), 64'(0));
            check({tag, "_regin_at_done"}, 64'((k == 0) ? Regin_a : Regin_b), 64'(0));
            check({tag, "_bytes_left"}, 64'((k == 0) ? exp_q0.size() : exp_q1.size()), 64'(0));
            if (start_in_done) begin
                set_start(k, 1'b1);
                @(posedge CLOCK); #1;
                set_start(k, 1'b0);
                @(negedge CLOCK);
                check({tag, "_start_in_done_ignored"}, 64'(busy_v[k]), 64'(0));
            end else begin
                @(negedge CLOCK);
            end
            check({tag, "_done_one_cycle"}, 64'(done_v[k]), 64'(0));
        end
    endtask

    initial begin
        int fs0, dc0;
        Reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        glitch_a = 1'b0;
        PC       = 32'h00400010;
        Instr    = 32'h00A00093;
        for (int k = 0; k < 2; k++) begin
            mon_act[k] = 0; mon_cnt[k] = 0; gap[k] = 0; had_frame[k] = 0;
            frames_started[k] = 0; done_cnt[k] = 0;
        end
        regin_prev = 0;
        regin_max  = 0;

        // Start held through reset must not launch a dump by itself
        start_a = 1'b1;
        repeat (3) @(negedge CLOCK);
        check("rst_tx", 64'(tx_v), 64'(2'b11));
        check("rst_busy", 64'(busy_v), 64'(0));
        check("rst_done", 64'(done_v), 64'(0));
        check("rst_regin_a", 64'(Regin_a), 64'(0));
        check("rst_regin_b", 64'(Regin_b), 64'(0));
        start_a = 1'b0;
        Reset   = 1'b0;
        repeat (2) @(negedge CLOCK);
        check("idle_after_rst", 64'(busy_v), 64'(0));

        // Two-register dump with the spec PC/Instr values
        PC    = 32'h00400010;
        Instr = 32'h00A00093;
        pulse_start(0);
        wait_done(0, "basic", 1'b0);

        // Start pulsed during the third byte is dropped
        fs0 = frames_started[0];
        dc0 = done_cnt[0];
        pulse_start(0);
        wait_frames(0, fs0 + 3, "busy_start");
        @(posedge CLOCK); #1;
        start_a = 1'b1;
        @(posedge CLOCK); #1;
        start_a = 1'b0;
        wait_done(0, "busy_start", 1'b0);
        repeat (100) @(negedge CLOCK);
        check("busy_start_single_done", 64'(done_cnt[0] - dc0), 64'(1));
        check("busy_start_no_redump", 64'(busy_v[0]), 64'(0));

        // Regout settles one cycle late; start raised in the done cycle is ignored
        glitch_a = 1'b1;
        pulse_start(0);
        wait_done(0, "glitch", 1'b1);
        glitch_a = 1'b0;
        repeat (10) @(negedge CLOCK);
        check("glitch_no_restart", 64'(busy_v[0]), 64'(0));

        // Full 32-register dump
        regin_max = 0;
        pulse_start(1);
        wait_done(1, "full", 1'b0);
        check("full_regin_max", 64'(regin_max), 64'(31));

        // Reset in the middle of a data bit of byte 5, then a fresh dump
        fs0 = frames_started[0];
        pulse_start(0);
        wait_frames(0, fs0 + 5, "reset_mid");
        repeat (10) @(negedge CLOCK);
        Reset = 1'b1;
        #1;
        check("reset_mid_tx", 64'(tx_v[0]), 64'(1));
        check("reset_mid_busy", 64'(busy_v[0]), 64'(0));
        check("reset_mid_regin", 64'(Regin_a), 64'(0));
        exp_q0.delete();
        repeat (2) @(negedge CLOCK);
        Reset = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("reset_mid_quiet", 64'(tx_v[0]), 64'(1));
        pulse_start(0);
        wait_done(0, "post_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
